// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready channel between the fetch stage and imem.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: fetch PC, IF/ID register and a three-state
// imem handshake (FETCH / HOLD with buffered word / DRAIN before a redirect).
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          StallF,
    input  logic          StallD,
    input  logic          PCSrcD,
    input  logic [31:0]   PCBranchD,
    input  logic          JumpD,
    input  logic [31:0]   PCJumpD,
    fetch_stage_if.master imem,
    output logic [31:0]   InstrD,
    output logic [31:0]   PCPlus4D,
    output logic          ValidD,
    output logic          FetchBusy
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] buf_reg, buf_next;
    logic [31:0] pend_reg, pend_next;
    logic [31:0] instr_reg, instr_next;
    logic [31:0] pcp4_reg, pcp4_next;
    logic        valid_reg, valid_next;

    logic        hold, redirect;
    logic [31:0] target, pc_plus4;

    assign hold     = StallF | StallD;
    assign redirect = !hold & (PCSrcD | JumpD);
    assign target   = PCSrcD ? PCBranchD : PCJumpD;
    assign pc_plus4 = pc_reg + 32'd4;

    // The request is gated by rst_n so an in-flight fetch is abandoned the moment reset asserts.
    assign imem.imem_req  = rst_n & (state_reg != HOLD);
    assign imem.imem_addr = pc_reg;

    assign InstrD   = instr_reg;
    assign PCPlus4D = pcp4_reg;
    assign ValidD   = valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_PC;
            buf_reg   <= 32'd0;
            pend_reg  <= 32'd0;
            instr_reg <= 32'd0;
            pcp4_reg  <= 32'd0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            buf_reg   <= buf_next;
            pend_reg  <= pend_next;
            instr_reg <= instr_next;
            pcp4_reg  <= pcp4_next;
            valid_reg <= valid_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        buf_next   = buf_reg;
        pend_next  = pend_reg;
        instr_next = instr_reg;
        pcp4_next  = pcp4_reg;
        valid_next = valid_reg;
        FetchBusy  = 1'b0;

        unique case (state_reg)
            FETCH: begin
                FetchBusy = rst_n & !imem.imem_ready;
                if (imem.imem_ready) begin
                    if (redirect) begin
                        pc_next    = target;
                        instr_next = 32'd0;
                        pcp4_next  = 32'd0;
                        valid_next = 1'b0;
                    end else if (!hold) begin
                        instr_next = imem.imem_rdata;
                        pcp4_next  = pc_plus4;
                        valid_next = 1'b1;
                        pc_next    = pc_plus4;
                    end else begin
                        buf_next   = imem.imem_rdata;
                        state_next = HOLD;
                    end
                end else if (redirect) begin
                    pend_next  = target;
                    instr_next = 32'd0;
                    pcp4_next  = 32'd0;
                    valid_next = 1'b0;
                    state_next = DRAIN;
                end else if (!hold) begin
                    instr_next = 32'd0;
                    pcp4_next  = 32'd0;
                    valid_next = 1'b0;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_next    = target;
                    instr_next = 32'd0;
                    pcp4_next  = 32'd0;
                    valid_next = 1'b0;
                    state_next = FETCH;
                end else if (!hold) begin
                    instr_next = buf_reg;
                    pcp4_next  = pc_plus4;
                    valid_next = 1'b1;
                    pc_next    = pc_plus4;
                    state_next = FETCH;
                end
            end
            DRAIN: begin
                FetchBusy = rst_n;
                if (redirect) pend_next = target;
                if (!hold) begin
                    instr_next = 32'd0;
                    pcp4_next  = 32'd0;
                    valid_next = 1'b0;
                end
                // A redirect arriving on the completing cycle is the newest decode decision, so it wins.
                if (imem.imem_ready) begin
                    pc_next    = redirect ? target : pend_reg;
                    state_next = FETCH;
                end
            end
            default: state_next = FETCH;
        endcase
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a transaction-level fetch model.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        StallF = 1'b0, StallD = 1'b0, PCSrcD = 1'b0, JumpD = 1'b0;
    logic [31:0] PCBranchD = 32'd0, PCJumpD = 32'd0;
    logic [31:0] InstrD, PCPlus4D;
    logic        ValidD, FetchBusy;

    fetch_stage_if imem_bus();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .StallF(StallF), .StallD(StallD),
        .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .JumpD(JumpD), .PCJumpD(PCJumpD),
        .imem(imem_bus.master),
        .InstrD(InstrD), .PCPlus4D(PCPlus4D),
        .ValidD(ValidD), .FetchBusy(FetchBusy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: fetch PC, an optional parked word, an optional pending redirect, IF/ID contents.
    logic [31:0] m_pc, m_parked_word, m_pend, m_instr, m_pcp4;
    logic        m_parked, m_draining, m_valid;
    logic        prev_wait;
    logic [31:0] prev_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_parked = 1'b0; m_parked_word = 32'd0;
        m_draining = 1'b0; m_pend = 32'd0;
        m_instr = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0;
        prev_wait = 1'b0; prev_addr = 32'd0;
    endtask

    task automatic deliver(input logic [31:0] word);
        m_instr = word; m_pcp4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
    endtask

    task automatic bubble();
        m_instr = 32'd0; m_pcp4 = 32'd0; m_valid = 1'b0;
    endtask

    // One clock: drive at negedge, check request side, apply edge to model, check IF/ID after edge.
    task automatic cyc(input logic sf, input logic sd, input logic b, input logic [31:0] pb,
                       input logic j, input logic [31:0] pj, input logic rdy, input logic [31:0] salt);
        logic hold, redir;
        logic [31:0] tgt, word;
        @(negedge clk);
        StallF = sf; StallD = sd; PCSrcD = b; PCBranchD = pb; JumpD = j; PCJumpD = pj;
        imem_bus.imem_ready = rdy;
        word = imem_bus.imem_addr ^ salt;
        imem_bus.imem_rdata = word;
        #1;
        chk("req", {31'd0, imem_bus.imem_req}, {31'd0, !m_parked});
        chk("addr", imem_bus.imem_addr, m_pc);
        chk("busy", {31'd0, FetchBusy}, {31'd0, m_parked ? 1'b0 : (m_draining ? 1'b1 : !rdy)});
        if (prev_wait && imem_bus.imem_req) chk("addr_stable", imem_bus.imem_addr, prev_addr);
        prev_wait = imem_bus.imem_req && !rdy;
        prev_addr = imem_bus.imem_addr;

        hold  = sf | sd;
        redir = !hold && (b || j);
        tgt   = b ? pb : pj;
        if (m_parked) begin
            if (redir) begin m_pc = tgt; bubble(); m_parked = 1'b0; end
            else if (!hold) begin deliver(m_parked_word); m_parked = 1'b0; end
        end else if (m_draining) begin
            if (redir) m_pend = tgt;
            if (!hold) bubble();
            if (rdy) begin m_pc = m_pend; m_draining = 1'b0; end
        end else if (rdy) begin
            if (redir) begin m_pc = tgt; bubble(); end
            else if (!hold) deliver(word);
            else begin m_parked = 1'b1; m_parked_word = word; end
        end else begin
            if (redir) begin m_pend = tgt; m_draining = 1'b1; bubble(); end
            else if (!hold) bubble();
        end

        @(posedge clk);
        #1;
        chk("instr", InstrD, m_instr);
        chk("pcp4", PCPlus4D, m_pcp4);
        chk("valid", {31'd0, ValidD}, {31'd0, m_valid});
        $display("cyc sf=%0b sd=%0b br=%0b j=%0b rdy=%0b -> addr=%h instr=%h pcp4=%h v=%0b",
                 sf, sd, b, j, rdy, imem_bus.imem_addr, InstrD, PCPlus4D, ValidD);
    endtask

    task automatic run(input logic rdy);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rdy, 32'd0);
    endtask

    initial begin
        logic sf, sd, b, j, rdy;
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'd0;
        model_reset();

        // Reset state
        #12;
        chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("rst_instr", InstrD, 32'd0);
        chk("rst_pcp4", PCPlus4D, 32'd0);
        chk("rst_valid", {31'd0, ValidD}, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        // Zero-wait streaming, instruction = address
        run(1'b1);
        chk("s0_pcp4", PCPlus4D, 32'd4);
        run(1'b1);
        chk("s1_instr", InstrD, 32'd4);
        chk("s1_addr", imem_bus.imem_addr, 32'd8);

        // Stall at PCF=8 for two cycles, then release
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'd0);
        chk("st_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("st_pcp4", PCPlus4D, 32'd8);
        cyc(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
        run(1'b0);
        chk("st_rel_instr", InstrD, 32'd8);
        chk("st_rel_pcp4", PCPlus4D, 32'd12);
        chk("st_rel_addr", imem_bus.imem_addr, 32'd12);

        // Branch while fetching 0x10
        run(1'b1);
        chk("br_addr_pre", imem_bus.imem_addr, 32'h10);
        cyc(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0, 1'b1, 32'd0);
        chk("br_bubble", {31'd0, ValidD}, 32'd0);
        chk("br_addr", imem_bus.imem_addr, 32'h40);
        run(1'b1);
        chk("br_instr", InstrD, 32'h40);

        // Wait-state drain at 0x20 with a jump in the first wait cycle
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h20, 1'b1, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h100, 1'b0, 32'd0);
        run(1'b0);
        run(1'b0);
        chk("dr_addr_hold", imem_bus.imem_addr, 32'h20);
        run(1'b1);
        chk("dr_addr", imem_bus.imem_addr, 32'h100);

        // Both redirects: branch wins; a redirect under StallD is ignored
        cyc(1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 32'd0);
        chk("both_addr", imem_bus.imem_addr, 32'h80);
        cyc(1'b0, 1'b1, 1'b1, 32'h300, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("stall_redir_addr", imem_bus.imem_addr, 32'h80);

        // PC wrap at 0xFFFF_FFFC
        cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'd0);
        run(1'b1);
        chk("wrap_addr", imem_bus.imem_addr, 32'd0);
        chk("wrap_pcp4", PCPlus4D, 32'd0);

        // Reset asserted mid-wait
        run(1'b0);
        @(negedge clk);
        imem_bus.imem_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        chk("mid_rst_addr", imem_bus.imem_addr, 32'd0);
        chk("mid_rst_valid", {31'd0, ValidD}, 32'd0);
        model_reset();
        @(negedge clk); rst_n = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            sf  = ($urandom_range(0, 9) == 0);
            sd  = ($urandom_range(0, 7) == 0);
            b   = ($urandom_range(0, 9) == 0);
            j   = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            cyc(sf, sd, b, $urandom & 32'hFFFF_FFFC, j, $urandom, rdy, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined MIPS core. It holds the fetch PC and the IF/ID pipeline register, and runs a request/ready handshake with instruction memory. It sits directly upstream of decode and consumes the hazard unit's StallF/StallD, plus the decode-stage redirect (PCSrcD/PCBranchD, JumpD/PCJumpD). It produces InstrD/PCPlus4D for decode; those instructions supply the RsD/RtD fields the hazard logic compares.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- StallF  input  1  hazard stall, fetch.
- StallD  input  1  hazard stall, decode.
- PCSrcD  input  1  taken branch resolved in decode.
- PCBranchD  input  32  branch target.
- JumpD  input  1  jump in decode.
- PCJumpD  input  32  jump target.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address (= PCF).
- imem_ready  input  1  imem_rdata valid this cycle; only meaningful while imem_req=1.
- imem_rdata  input  32  fetched instruction.
- InstrD  output  32  IF/ID instruction.
- PCPlus4D  output  32  IF/ID PC+4.
- ValidD  output  1  IF/ID holds a real instruction (0 = bubble, InstrD = 0).
- FetchBusy  output  1  request outstanding and not yet answered.

## Operation
- Definitions:
  - hold = StallF | StallD.
  - redirect = !hold & (PCSrcD | JumpD).
  - target = PCSrcD ? PCBranchD : PCJumpD. PCSrcD wins when both are asserted.
  - While hold = 1, redirect is ignored (decode not final).
- The state machine has three states.
- FETCH: imem_req = 1 and imem_addr = PCF; FetchBusy = !imem_ready. Transitions:
  - ready & redirect: discard rdata; PCF <= target; IF/ID <= bubble; stay FETCH.
  - ready & !hold: IF/ID <= {rdata, PCF+4, valid}; PCF <= PCF+4; stay FETCH.
  - ready & hold: capture rdata into buffer; IF/ID unchanged; go HOLD.
  - !ready & redirect: latch target into pending register; IF/ID <= bubble; go DRAIN.
  - !ready & !hold: IF/ID <= bubble; stay FETCH.
  - !ready & hold: IF/ID unchanged; stay FETCH.
- HOLD: imem_req = 0 and FetchBusy = 0. Transitions:
  - redirect: drop buffer; PCF <= target; IF/ID <= bubble; go FETCH.
  - !hold: IF/ID <= {buffer, PCF+4, valid}; PCF <= PCF+4; go FETCH.
  - hold: stay HOLD.
- DRAIN: imem_req = 1 and imem_addr = PCF (the old address is held; the request is never withdrawn). FetchBusy = 1. IF/ID gets a bubble when !hold and is unchanged when hold. Transitions:
  - ready: discard rdata; PCF <= pending target; go FETCH.
  - A further redirect while in DRAIN overwrites the pending target.
- Handshake: once imem_req rises, imem_addr stays stable until the cycle imem_ready = 1.
- PC arithmetic is 32-bit and wraps modulo 2^32: 32'hFFFF_FFFC + 4 = 0. Low two address bits are passed through unchecked.

## Timing
- Reset (rst_n = 0, asynchronous) sets:
  - PCF = RESET_PC and state = FETCH.
  - InstrD = 0, PCPlus4D = 0, ValidD = 0.
  - Buffer = 0 and pending target = 0.
  - imem_req is gated to 0 while rst_n = 0.
- First request: imem_req = 1 in the first cycle after rst_n rises.
- Latency with zero-wait memory (ready in the request cycle): an instruction appears in IF/ID one edge after its address is presented. Throughput is one instruction per cycle.
- Latency with N wait cycles: N bubbles (ValidD = 0) enter decode unless hold is asserted.
- Redirect: the target address appears on imem_addr the cycle after the redirect edge, or after drain completes. Exactly one bubble is inserted for a redirect from FETCH-ready.
- Reset asserted mid-handshake abandons the request immediately. Memory must tolerate req dropping without ready.

## Test plan
- Reset release with zero-wait memory returning instruction = address: imem_addr sequence 0, 4, 8, ...; InstrD/PCPlus4D = 0/4, 4/8, 8/12; ValidD = 1 from the second edge.
- Stall: assert StallF = StallD = 1 for 2 cycles while PCF = 8 with ready = 1 → state HOLD and imem_req = 0. IF/ID keeps PCPlus4D = 8. After release, InstrD = 8 and PCPlus4D = 12, then fetch resumes at 12.
- Branch: PCSrcD = 1 with PCBranchD = 0x40 while fetching 0x10 → next IF/ID is a bubble, next imem_addr = 0x40, then InstrD = 0x40 with ValidD = 1.
- Wait-state drain: ready delayed 3 cycles at address 0x20, with JumpD = 1 and PCJumpD = 0x100 in the first wait cycle → imem_addr stays 0x20 until ready, response discarded, then imem_addr = 0x100. FetchBusy = 1 for all 3 cycles.
- Both redirects (PCSrcD = JumpD = 1, PCBranchD = 0x80, PCJumpD = 0x200) → next address 0x80. A redirect with StallD = 1 is ignored and PC holds.
- Wrap and reset: PCF = 0xFFFF_FFFC fetch → next address 0 and PCPlus4D = 0. Asserting rst_n = 0 mid-wait → imem_req = 0 at once and PCF = RESET_PC.
